// File: rtl/uart_adder_pkg.sv
// Shared encodings and frame geometry for the UART adder frame controller.
package uart_adder_pkg;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RX_A     = 3'd1;
   localparam logic [2:0] S_RX_B     = 3'd2;
   localparam logic [2:0] S_RX_FLAGS = 3'd3;
   localparam logic [2:0] S_ADD      = 3'd4;
   localparam logic [2:0] S_TX_LOAD  = 3'd5;
   localparam logic [2:0] S_TX_WAIT  = 3'd6;

   localparam int OPND_BYTES = 4;
   localparam int RESP_BYTES = 5;

   localparam logic [1:0] OPND_LAST = 2'(OPND_BYTES - 1);
   localparam logic [2:0] RESP_LAST = 3'(RESP_BYTES - 1);

   // Response byte idx of the 33-bit result; byte 4 carries only the carry-out.
   function automatic logic [7:0] resp_byte(input logic [32:0] res, input logic [2:0] idx);
      logic [39:0] shifted;
      shifted = {7'b0, res} >> {idx, 3'b000};
      return shifted[7:0];
   endfunction

endpackage

// File: rtl/uart_adder_ctrl_frame_timeout.sv
// Inter-byte gap counter; tc pulses on the clock that completes TIMEOUT_CLKS idle clocks.
module frame_timeout #(
   parameter int TIMEOUT_CLKS = 65535
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CLKS - 1);

   logic [CW-1:0] cnt;

   assign tc = en & ~clr & (cnt == TC_VAL);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (clr || tc) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_adder_ctrl.sv
// Frame controller: assembles A/B/Cin from UART bytes, drives the adder, streams the result back.
//
// state      | meaning
// S_IDLE     | waiting for the sync byte, other bytes discarded
// S_RX_A     | shifting four A bytes, LSB first
// S_RX_B     | shifting four B bytes, LSB first
// S_RX_FLAGS | waiting for the flags byte, then operands load
// S_ADD      | adder settle interval, then result capture
// S_TX_LOAD  | waiting for an idle transmitter, then start one byte
// S_TX_WAIT  | waiting for the transmitter to finish the byte
module uart_adder_ctrl
   import uart_adder_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         ADD_WAIT     = 4,
   parameter int         TIMEOUT_CLKS = 65535
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        Rx_DV_in,
   input  logic [7:0]  Rx_Byte_in,
   input  logic [31:0] Sum_in,
   input  logic        Cout_in,
   output logic [31:0] A_out,
   output logic [31:0] B_out,
   output logic        Cin_out,
   input  logic        Tx_Active_in,
   input  logic        Tx_Done_in,
   output logic        Tx_DV_out,
   output logic [7:0]  Tx_Byte_out,
   output logic        Busy_out,
   output logic        Err_out
);

   localparam int AW = $clog2(ADD_WAIT + 1);
   localparam logic [AW-1:0] ADD_LOAD = AW'(ADD_WAIT - 1);

   logic [2:0]    state;
   logic [1:0]    byte_idx;
   logic [2:0]    tx_idx;
   logic [31:0]   a_shadow;
   logic [31:0]   b_shadow;
   logic [32:0]   result;
   logic [AW-1:0] wait_cnt;
   logic          in_rx;
   logic          in_busy_op;
   logic          gap_tc;

   assign in_rx      = (state == S_RX_A) || (state == S_RX_B) || (state == S_RX_FLAGS);
   assign in_busy_op = (state == S_ADD) || (state == S_TX_LOAD) || (state == S_TX_WAIT);

   frame_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
      .clk_sys (CLK),
      .rst_b   (RST_N),
      .clr     (Rx_DV_in | ~in_rx),
      .en      (in_rx),
      .tc      (gap_tc)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= S_IDLE;
         byte_idx    <= '0;
         tx_idx      <= '0;
         a_shadow    <= '0;
         b_shadow    <= '0;
         result      <= '0;
         wait_cnt    <= '0;
         A_out       <= '0;
         B_out       <= '0;
         Cin_out     <= 1'b0;
         Tx_DV_out   <= 1'b0;
         Tx_Byte_out <= '0;
         Busy_out    <= 1'b0;
         Err_out     <= 1'b0;
      end else begin
         Tx_DV_out <= 1'b0;
         // Bytes arriving while the adder or transmitter owns the frame are dropped.
         Err_out   <= in_busy_op & Rx_DV_in;

         case (state)
            S_IDLE: begin
               if (Rx_DV_in && (Rx_Byte_in == SYNC_BYTE)) begin
                  state    <= S_RX_A;
                  Busy_out <= 1'b1;
                  byte_idx <= '0;
               end
            end
            S_RX_A, S_RX_B, S_RX_FLAGS: begin
               if (gap_tc) begin
                  state    <= S_IDLE;
                  Busy_out <= 1'b0;
                  Err_out  <= 1'b1;
                  a_shadow <= '0;
                  b_shadow <= '0;
                  byte_idx <= '0;
               end else if (Rx_DV_in) begin
                  if (state == S_RX_FLAGS) begin
                     A_out    <= a_shadow;
                     B_out    <= b_shadow;
                     Cin_out  <= Rx_Byte_in[0];
                     wait_cnt <= ADD_LOAD;
                     state    <= S_ADD;
                  end else begin
                     if (state == S_RX_A) a_shadow <= {Rx_Byte_in, a_shadow[31:8]};
                     else                 b_shadow <= {Rx_Byte_in, b_shadow[31:8]};
                     byte_idx <= byte_idx + 2'd1;
                     if (byte_idx == OPND_LAST) state <= (state == S_RX_A) ? S_RX_B : S_RX_FLAGS;
                  end
               end
            end
            S_ADD: begin
               if (wait_cnt == '0) begin
                  result <= {Cout_in, Sum_in};
                  tx_idx <= '0;
                  state  <= S_TX_LOAD;
               end else begin
                  wait_cnt <= wait_cnt - AW'(1);
               end
            end
            S_TX_LOAD: begin
               if (!Tx_Active_in) begin
                  Tx_Byte_out <= resp_byte(result, tx_idx);
                  Tx_DV_out   <= 1'b1;
                  state       <= S_TX_WAIT;
               end
            end
            S_TX_WAIT: begin
               if (Tx_Done_in) begin
                  if (tx_idx == RESP_LAST) begin
                     tx_idx   <= '0;
                     Busy_out <= 1'b0;
                     state    <= S_IDLE;
                  end else begin
                     tx_idx <= tx_idx + 3'd1;
                     state  <= S_TX_LOAD;
                  end
               end
            end
            default: begin
               state    <= S_IDLE;
               Busy_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_adder_ctrl.sv
// Self-checking bench for uart_adder_ctrl: vector table, random frames, timeout, drop and reset sequences.
module tb_uart_adder_ctrl;

   localparam int         T_CLKS  = 40;
   localparam int         A_WAIT  = 4;
   localparam logic [7:0] SYNC    = 8'hA5;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  flags;
      bit          junk;
      int          gap;
      int          pre;
      int          inject;
      logic [39:0] exp;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        rx_dv = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        tx_active = 1'b0;
   logic        tx_done = 1'b0;
   logic [31:0] sum;
   logic        cout;
   logic [31:0] a_out, b_out;
   logic        cin_out, tx_dv, busy, err;
   logic [7:0]  tx_byte;

   int n_cmp = 0;
   int n_bad = 0;
   int err_seen = 0;
   int dv_double = 0;
   logic prev_dv = 1'b0;
   logic [7:0] got_q [$];
   logic [31:0] prev_a = 0, prev_b = 0;
   logic        prev_cin = 0;

   always #5 CLK = ~CLK;

   // Ideal adder driven by the controller's operands.
   assign {cout, sum} = {1'b0, a_out} + {1'b0, b_out} + {32'b0, cin_out};

   uart_adder_ctrl #(.SYNC_BYTE(SYNC), .ADD_WAIT(A_WAIT), .TIMEOUT_CLKS(T_CLKS)) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .Rx_DV_in     (rx_dv),
      .Rx_Byte_in   (rx_byte),
      .Sum_in       (sum),
      .Cout_in      (cout),
      .A_out        (a_out),
      .B_out        (b_out),
      .Cin_out      (cin_out),
      .Tx_Active_in (tx_active),
      .Tx_Done_in   (tx_done),
      .Tx_DV_out    (tx_dv),
      .Tx_Byte_out  (tx_byte),
      .Busy_out     (busy),
      .Err_out      (err)
   );

   always @(negedge CLK) begin
      if (err) err_seen++;
      if (tx_dv && prev_dv) dv_double++;
      prev_dv = tx_dv;
   end

   function automatic logic [39:0] model(input logic [31:0] a, input logic [31:0] b, input logic [7:0] flags);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b} + {32'b0, flags[0]};
      return {7'b0, s};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_dv = 1'b1;
      rx_byte = b;
      tick();
      rx_dv = 1'b0;
   endtask

   task automatic do_gap(input int g);
      int n;
      n = (g < 0) ? int'($urandom_range(0, 3)) : g;
      repeat (n) tick();
   endtask

   task automatic serve_tx(input int pre_in, input int inject_at, input int abort_after, output int first);
      int cyc, hold, pre, n_done, stable_bad;
      logic [7:0] cur;
      logic done_last;
      cyc = 0; hold = 0; pre = pre_in; n_done = 0; stable_bad = 0; cur = 8'h00; first = -1;
      got_q.delete();
      tx_active = (pre_in > 0);
      while (cyc < 600) begin
         tick();
         cyc++;
         rx_dv = 1'b0;
         done_last = tx_done;
         tx_done = 1'b0;
         if (inject_at > 0 && cyc == inject_at + 1) chk("drop_err_pulse", 64'(err), 64'(1));
         if (done_last && n_done == 5) begin
            chk("busy_fall", 64'(busy), 64'(0));
            break;
         end
         if (abort_after > 0 && n_done == abort_after) break;
         if (tx_dv) begin
            chk("dv_active_low", 64'(tx_active), 64'(0));
            if (first < 0) first = cyc;
            got_q.push_back(tx_byte);
            cur = tx_byte;
            tx_active = 1'b1;
            hold = $urandom_range(1, 4);
         end else if (hold > 0) begin
            if (tx_byte !== cur) stable_bad++;
            hold--;
            if (hold == 0) begin
               tx_done = 1'b1;
               tx_active = 1'b0;
               n_done++;
            end
         end else if (pre > 0) begin
            pre--;
            if (pre == 0) tx_active = 1'b0;
         end
         if (cyc == inject_at) begin
            rx_dv = 1'b1;
            rx_byte = 8'($urandom_range(0, 255));
         end
      end
      chk("tx_done_count", 64'(n_done), 64'((abort_after > 0) ? abort_after : 5));
      chk("tx_byte_stable", 64'(stable_bad), 64'(0));
   endtask

   task automatic run_frame(input vec_t v, input int abort_after);
      int e0, first, exp_first;
      logic [31:0] sh;
      if (v.junk) begin
         send_byte(8'h00); tick();
         send_byte(8'h3C); tick();
         chk("junk_keeps_idle", 64'(busy), 64'(0));
      end
      e0 = err_seen;
      send_byte(SYNC);
      chk("busy_rise", 64'(busy), 64'(1));
      sh = v.a;
      for (int i = 0; i < 4; i++) begin
         do_gap(v.gap); send_byte(sh[7:0]); sh = sh >> 8;
      end
      sh = v.b;
      for (int i = 0; i < 4; i++) begin
         do_gap(v.gap); send_byte(sh[7:0]); sh = sh >> 8;
      end
      do_gap(v.gap);
      chk("opnd_hold", 64'(a_out), 64'(prev_a));
      send_byte(v.flags);
      chk("a_out", 64'(a_out), 64'(v.a));
      chk("b_out", 64'(b_out), 64'(v.b));
      chk("cin_out", 64'(cin_out), 64'(v.flags[0]));
      prev_a = v.a; prev_b = v.b; prev_cin = v.flags[0];
      serve_tx(v.pre, v.inject, abort_after, first);
      if (abort_after > 0) return;
      exp_first = (v.pre + 1 > A_WAIT + 1) ? v.pre + 1 : A_WAIT + 1;
      chk("first_dv_latency", 64'(first), 64'(exp_first));
      chk("tx_len", 64'(got_q.size()), 64'(5));
      for (int i = 0; i < 5; i++) begin
         if (i < got_q.size())
            chk($sformatf("tx_byte%0d", i), 64'(got_q[i]), 64'((v.exp >> (8 * i)) & 40'hFF));
      end
      chk("err_pulses", 64'(err_seen - e0), 64'(v.inject > 0 ? 1 : 0));
   endtask

   initial begin
      vec_t vecs[6];
      vec_t rv;
      int n, e0, dv_cnt;

      vecs[0] = '{32'h00000001, 32'hFFFFFFFF, 8'h00, 1'b0, -1, 0, 0, 40'h01_00000000};
      vecs[1] = '{32'h12345678, 32'h11111111, 8'h01, 1'b0, -1, 0, 0, 40'h00_2345678A};
      vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 1'b1, -1, 8, 0, 40'h01_FFFFFFFF};
      vecs[3] = '{32'hA5A5A5A5, 32'h000000A5, 8'hFE, 1'b0, T_CLKS - 1, 0, 0, 40'h00_A5A5A64A};
      vecs[4] = '{32'h00000000, 32'h00000000, 8'h00, 1'b0, -1, 0, 12, 40'h00_00000000};
      vecs[5] = '{32'h7FFFFFFF, 32'h00000000, 8'h01, 1'b0, -1, 0, 2, 40'h00_80000000};

      repeat (3) @(posedge CLK);
      #1;
      chk("rst_a", 64'(a_out), 64'(0));
      chk("rst_b", 64'(b_out), 64'(0));
      chk("rst_cin", 64'(cin_out), 64'(0));
      chk("rst_tx_dv", 64'(tx_dv), 64'(0));
      chk("rst_tx_byte", 64'(tx_byte), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      RST_N = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_frame(vecs[i], 0);

      for (int i = 0; i < 8; i++) begin
         rv.a = $urandom; rv.b = $urandom; rv.flags = 8'($urandom_range(0, 255));
         rv.junk = ($urandom_range(0, 1) == 1);
         rv.gap = -1;
         rv.pre = ($urandom_range(0, 1) == 1) ? 6 : 0;
         rv.inject = 0;
         rv.exp = model(rv.a, rv.b, rv.flags);
         run_frame(rv, 0);
      end

      // Frame timeout after two operand bytes.
      e0 = err_seen;
      send_byte(SYNC); tick(); tick();
      send_byte(8'h01); tick();
      send_byte(8'h02);
      n = 0;
      while (n < 2 * T_CLKS && !err) begin
         tick();
         n++;
      end
      chk("timeout_clks", 64'(n), 64'(T_CLKS));
      chk("timeout_busy", 64'(busy), 64'(0));
      chk("timeout_a_kept", 64'(a_out), 64'(prev_a));
      chk("timeout_b_kept", 64'(b_out), 64'(prev_b));
      chk("timeout_cin_kept", 64'(cin_out), 64'(prev_cin));
      tick();
      chk("timeout_single_err", 64'(err_seen - e0), 64'(1));

      // Reset after the third response byte.
      rv.a = 32'hDEADBEEF; rv.b = 32'h01020304; rv.flags = 8'h01;
      rv.junk = 1'b0; rv.gap = -1; rv.pre = 0; rv.inject = 0;
      rv.exp = model(rv.a, rv.b, rv.flags);
      run_frame(rv, 3);
      RST_N = 1'b0;
      #1;
      chk("abort_a", 64'(a_out), 64'(0));
      chk("abort_b", 64'(b_out), 64'(0));
      chk("abort_cin", 64'(cin_out), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_tx_byte", 64'(tx_byte), 64'(0));
      dv_cnt = 0;
      repeat (3) begin
         tick();
         if (tx_dv) dv_cnt++;
      end
      RST_N = 1'b1;
      prev_a = 0; prev_b = 0; prev_cin = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (tx_dv) dv_cnt++;
      end
      chk("abort_no_dv", 64'(dv_cnt), 64'(0));
      send_byte(8'h11); tick();
      send_byte(8'h22); tick();
      chk("abort_needs_sync", 64'(busy), 64'(0));
      rv.a = 32'hCAFEF00D; rv.b = 32'h35010FF3; rv.flags = 8'h00;
      rv.exp = model(rv.a, rv.b, rv.flags);
      run_frame(rv, 0);

      chk("dv_never_double", 64'(dv_double), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
